// File: rtl/regunit_pkg.sv
// regunit_pkg: shared Register Unit constants and types
// Used by the write-enable decoder, the register bank and the writeback stage.
package regunit_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    typedef logic [4:0] reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;
    localparam reg_idx_t REG_SP = 5'd2;
    localparam reg_idx_t REG_GP = 5'd3;
endpackage

// File: rtl/reg_cell.sv
// reg_cell: one W-bit register with write enable and parameterised reset value
// Ports: clk, rst_n (async active-low), en (write enable), d (write data), q (stored value)
module reg_cell #(
    parameter int W = 32,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= RST;
        else if (en) q <= d;
endmodule

// File: rtl/reg_bank_32x32.sv
// reg_bank_32x32: 32 x XLEN register bank with one-hot write, write-first bypass reads
// Ports: clk, rst_n (async active-low), enS (one-hot write enable), DataWr (write data),
//        rs1/rs2 (read indices), RuRs1/RuRs2 (read data), wr_err (sticky multi-hot flag),
//        wr_cnt (accepted-write counter, wraps)
module reg_bank_32x32
    import regunit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter logic [XLEN-1:0] SP_INIT = 32'h0000_03FC,
    parameter logic [XLEN-1:0] GP_INIT = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREG-1:0] enS,
    input  logic [XLEN-1:0] DataWr,
    input  reg_idx_t        rs1,
    input  reg_idx_t        rs2,
    output logic [XLEN-1:0] RuRs1,
    output logic [XLEN-1:0] RuRs2,
    output logic            wr_err,
    output logic [15:0]     wr_cnt
);
    localparam logic [NREG-2:0] ONE = {{(NREG-2){1'b0}}, 1'b1};

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-2:0] hot;
    logic            multi;
    logic            single;

    assign regs[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_reg
        reg_cell #(
            .W  (XLEN),
            .RST((i == int'(REG_SP)) ? SP_INIT : (i == int'(REG_GP)) ? GP_INIT : {XLEN{1'b0}})
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (enS[i]),
            .d    (DataWr),
            .q    (regs[i])
        );
    end

    // enS[0] never counts: x0 is not storage. Clearing the lowest set bit
    // leaves something behind only when two or more bits were set.
    assign hot    = enS[NREG-1:1];
    assign multi  = (hot & (hot - ONE)) != '0;
    assign single = (hot != '0) && !multi;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_err <= 1'b0;
            wr_cnt <= '0;
        end else begin
            if (multi) wr_err <= 1'b1;
            if (single) wr_cnt <= wr_cnt + 16'd1;
        end

    // Write-first bypass: a same-cycle writeback is visible before the edge.
    assign RuRs1 = (rs1 == '0) ? '0 : enS[rs1] ? DataWr : regs[rs1];
    assign RuRs2 = (rs2 == '0) ? '0 : enS[rs2] ? DataWr : regs[rs2];
endmodule

// File: tb/tb_reg_bank_32x32.sv
// tb_reg_bank_32x32: scoreboard bench for reg_bank_32x32
module tb_reg_bank_32x32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] enS;
  logic [31:0] DataWr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] RuRs1;
  logic [31:0] RuRs2;
  logic        wr_err;
  logic [15:0] wr_cnt;
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  reg_bank_32x32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enS   (enS),
    .DataWr(DataWr),
    .rs1   (rs1),
    .rs2   (rs2),
    .RuRs1 (RuRs1),
    .RuRs2 (RuRs2),
    .wr_err(wr_err),
    .wr_cnt(wr_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = (e.sel == 0) ? RuRs1 : (e.sel == 1) ? RuRs2 :
            (e.sel == 2) ? {31'd0, wr_err} : {16'd0, wr_cnt};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: test did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel = sel;
    e.exp = exp;
    q.push_back(e);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int idx, input logic [31:0] d);
    enS = 32'd1 << idx;
    DataWr = d;
    tick();
    enS = '0;
  endtask
  initial begin
    rst_n = 1'b1;
    enS = '0;
    DataWr = '0;
    rs1 = '0;
    rs2 = '0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    rs1 = 5'd2;
    #1;
    checks++;
    if (RuRs1 !== 32'h3FC || RuRs2 !== 32'h0 || wr_err !== 1'b0 || wr_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_direct: x2=%h x0=%h err=%b cnt=%h", RuRs1, RuRs2, wr_err, wr_cnt);
    end
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      expect_val("rst_rs1", 0, (i == 2) ? 32'h3FC : 32'h0);
      expect_val("rst_rs2", 1, (31 - i == 2) ? 32'h3FC : 32'h0);
      tick();
    end
    expect_val("rst_err", 2, 32'd0);
    expect_val("rst_cnt", 3, 32'd0);
    tick();
    rst_n = 1'b1;
    enS = 32'h0000_0020;
    DataWr = 32'hDEADBEEF;
    rs1 = 5'd5;
    expect_val("wr_bypass", 0, 32'hDEADBEEF);
    tick();
    enS = '0;
    DataWr = 32'h0;
    expect_val("wr_read", 0, 32'hDEADBEEF);
    expect_val("wr_cnt1", 3, 32'd1);
    tick();
    enS = 32'h0000_0400;
    DataWr = 32'h1234;
    rs1 = 5'd10;
    rs2 = 5'd10;
    expect_val("byp_rs1", 0, 32'h1234);
    expect_val("byp_rs2", 1, 32'h1234);
    expect_val("byp_old_cnt", 3, 32'd1);
    tick();
    enS = '0;
    DataWr = 32'h0;
    expect_val("byp_stored", 0, 32'h1234);
    expect_val("byp_cnt2", 3, 32'd2);
    tick();
    enS = 32'h1;
    DataWr = 32'hFFFF_FFFF;
    rs1 = 5'd0;
    rs2 = 5'd5;
    expect_val("x0_bypass", 0, 32'h0);
    tick();
    enS = '0;
    expect_val("x0_read", 0, 32'h0);
    expect_val("x0_other", 1, 32'hDEADBEEF);
    expect_val("x0_cnt", 3, 32'd2);
    expect_val("x0_err", 2, 32'd0);
    tick();
    enS = 32'h6;
    DataWr = 32'hA5;
    tick();
    enS = '0;
    rs1 = 5'd1;
    rs2 = 5'd2;
    expect_val("mh_x1", 0, 32'hA5);
    expect_val("mh_x2", 1, 32'hA5);
    expect_val("mh_err", 2, 32'd1);
    expect_val("mh_cnt", 3, 32'd2);
    tick();
    wr(7, 32'h77);
    rs1 = 5'd7;
    expect_val("mh_sticky", 2, 32'd1);
    expect_val("mh_cnt3", 3, 32'd3);
    expect_val("mh_x7", 0, 32'h77);
    tick();
    rst_n = 1'b0;
    rs1 = 5'd1;
    rs2 = 5'd2;
    expect_val("rst2_x1", 0, 32'h0);
    expect_val("rst2_x2", 1, 32'h3FC);
    expect_val("rst2_err", 2, 32'd0);
    expect_val("rst2_cnt", 3, 32'd0);
    tick();
    enS = 32'h10;
    DataWr = 32'h44;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    enS = '0;
    rs1 = 5'd4;
    expect_val("rel_x4", 0, 32'h44);
    expect_val("rel_cnt", 3, 32'd1);
    tick();
    for (int k = 0; k < 65534; k++) wr(k % 31 + 1, 32'(k));
    rs2 = 5'd31;
    expect_val("wrap_ffff", 3, 32'hFFFF);
    expect_val("wrap_last", 1, 32'h0000_FFFD);
    tick();
    wr(9, 32'hC0FFEE);
    rs1 = 5'd9;
    expect_val("wrap_zero", 3, 32'd0);
    expect_val("wrap_err", 2, 32'd0);
    expect_val("wrap_x9", 0, 32'hC0FFEE);
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_bank_32x32.md
Name: reg_bank_32x32

Overview:
Register bank of the segmented RISC-V core; sits directly downstream of the 5-to-32 write-enable decoder in the Register Unit.
- Holds 32 x 32-bit general registers.
- Writes on the clock edge using the decoder's one-hot enable vector.
- Serves two combinational read ports (rs1, rs2) to the decode stage, with write-first bypass so a writeback and a read in the same cycle return the new value.
- Flags illegal (non-one-hot) enable vectors.

Parameters:
XLEN, 32, data width of every register and data port.
NREG, 32, number of registers; enable vector width.
SP_INIT, 32'h0000_03FC, reset value of x2 (stack pointer).
GP_INIT, 32'h0000_0000, reset value of x3 (global pointer).

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
enS  input  NREG  one-hot write enable from the decoder; bit i writes register xi; all-zero = no write.
DataWr  input  XLEN  writeback data.
rs1  input  5  read-port-1 register index.
rs2  input  5  read-port-2 register index.
RuRs1  output  XLEN  read data port 1.
RuRs2  output  XLEN  read data port 2.
wr_err  output  1  sticky flag: an enable vector with more than one bit set was seen.
wr_cnt  output  16  count of accepted writes (debug).

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - All registers 0, except x2 = SP_INIT and x3 = GP_INIT.
  - wr_err = 0; wr_cnt = 0.
  - While reset is held, RuRs1/RuRs2 reflect the reset contents.
- Write, on the rising edge with rst_n high:
  - For each i in 1..31 with enS[i]=1, register xi <= DataWr.
  - enS[0] is ignored; x0 is never stored and always reads 0.
- Accepted write: enS[31:1] has exactly one bit set.
  - wr_cnt increments by 1 per accepted write.
  - wr_cnt wraps 16'hFFFF -> 0 with no flag.
- Multi-hot enS (two or more bits of enS[31:1] set):
  - All enabled registers are still written with DataWr. Write behaviour is not gated by the error.
  - wr_cnt does not increment.
  - wr_err is set on that edge and stays 1 until reset.
- enS = 0, or only enS[0] set: no state change; wr_cnt unchanged.
- Read (combinational, zero latency):
  - RuRs1 = 0 if rs1 == 0.
  - Else RuRs1 = DataWr if enS[rs1] == 1 (bypass, write-first).
  - Else RuRs1 = x[rs1].
  - RuRs2 follows the same rules with rs2.
  - Both ports may address the same register; both return the same value.
- Simultaneous write and read of the same register: the read port shows DataWr in that cycle; the stored value shows it from the next cycle.
- Reset released mid-operation: the first rising edge after rst_n goes high performs a normal write if enS is non-zero.
- X-safety: rs1/rs2 are always 5-bit in-range; no out-of-range case exists.

Decomposition:
- Shared package regunit_pkg:
  - XLEN and NREG constants.
  - typedef reg_idx_t (logic [4:0]).
  - typedef xword_t (logic [XLEN-1:0]).
  - Constants REG_SP = 5'd2 and REG_GP = 5'd3.
  - This package is also used by the decoder and writeback stage.
- Sub-module reg_cell: one XLEN-bit register with enable and a parameterised reset value. Instantiated 31 times (x1..x31) by generate; x0 is a constant.
- Read muxes, bypass, one-hot checker and counter live in reg_bank_32x32.

Test Plan:
- Reset: pulse rst_n low mid-cycle, read all 32 indices -> x2 = 32'h3FC, all others 0; wr_err = 0; wr_cnt = 0.
- Basic write/read: enS = 32'h0000_0020, DataWr = 32'hDEADBEEF, one edge; then rs1 = 5 -> RuRs1 = DEADBEEF; wr_cnt = 1.
- Bypass: enS = 32'h0000_0400, DataWr = 32'h1234, rs1 = rs2 = 10, same cycle before the edge -> both ports read 32'h1234 combinationally.
- x0 protection: enS = 32'h1, DataWr = 32'hFFFF_FFFF, edge; rs1 = 0 -> 0; wr_cnt unchanged.
- Multi-hot: enS = 32'h0000_0006, DataWr = 32'hA5 -> x1 = x2 = 32'hA5; wr_err = 1 and sticky; wr_cnt unchanged; wr_err is cleared only by rst_n.
- Counter wrap: 65536 accepted writes -> wr_cnt returns to 0; wr_err stays 0.
